spmv_hbm_rd_scheduler: RTL
==========================

Name: spmv_hbm_rd_scheduler

Overview:
- Read-side scheduler for the SpMV vector-loader HBM AXI3 port (256-bit data, 4-bit len).
- Accepts linear read jobs from two requesters: ctx0 = Y-vector readback, ctx1 = X-vector prefetch.
- Splits each job into HBM bursts, interleaves the two jobs round-robin per burst, limits outstanding bursts, and routes R beats back tagged by context.
- Issues a per-context done pulse and reports a sticky error flag.

Parameters:
- MAX_OUTSTANDING, 8, maximum AR bursts in flight across both contexts (1..15).
- ID_BASE, 6'h0, arid = ID_BASE | ctx; ID_BASE[0] must be 0.
- BEAT_W, 16, width of the job beat count.

Ports:
- pcie_aclk  in  1  clock
- pcie_areset  in  1  synchronous, active-high reset
- req_valid  in  2  per-context job request
- req_ready  out  2  context idle, job accepted on valid&ready
- req_addr  in  2x33  job byte address; bits [4:0] ignored (treated as 0)
- req_beats  in  2x BEAT_W  job length in 32-byte beats
- done  out  2  one-cycle pulse, all beats of the job returned
- err  out  2  sticky: any rresp!=0 in the current job; cleared on accept
- m_axi_hbm_araddr  out  33  burst address
- m_axi_hbm_arburst  out  2  constant 2'b01 (INCR)
- m_axi_hbm_arid  out  6  ID_BASE | ctx
- m_axi_hbm_arlen  out  4  beats-1
- m_axi_hbm_arsize  out  3  constant 3'b101 (32 B)
- m_axi_hbm_arvalid  out  1
- m_axi_hbm_arready  in  1
- m_axi_hbm_rdata  in  256
- m_axi_hbm_rid  in  6
- m_axi_hbm_rlast  in  1
- m_axi_hbm_rresp  in  2
- m_axi_hbm_rvalid  in  1
- m_axi_hbm_rready  out  1  equals rd_ready
- rd_data  out  256  rdata passthrough (combinational)
- rd_valid  out  1  rvalid passthrough
- rd_ctx  out  1  rid[0]
- rd_last  out  1  last beat of that context's job
- rd_ready  in  1  consumer backpressure

Behaviour:
- Reset values:
  - arvalid=0, araddr=0, arlen=0, arid=ID_BASE.
  - done=0, err=0, req_ready=2'b11.
  - All counters 0, rr pointer=0.
- Per context, in registers:
  - next_addr, to_issue (beats not yet requested), to_recv (beats not yet returned), busy.
- Accept (valid&ready):
  - next_addr = {req_addr[32:5],5'b0}; to_issue = to_recv = req_beats; busy=1; err cleared.
  - req_ready = !busy.
- Zero-length job (req_beats=0): accepted, done pulses the next cycle, no AR issued, busy=1 for one cycle only.
- Burst length:
  - len = min(16, to_issue, beats to next 4 KB boundary), where beats to boundary = (4096 - next_addr[11:0])/32.
  - arlen = len-1.
- Issue FSM:
  - IDLE: eligible = busy & to_issue!=0. If any context is eligible and outstanding<MAX_OUTSTANDING, pick by round-robin and go to ISSUE. araddr/arlen/arid are registered on entry.
  - ISSUE: hold arvalid=1 and all AR fields stable until arready. On the handshake: next_addr += len*32, to_issue -= len, outstanding++, rr = other ctx, go to IDLE.
  - First arvalid comes no earlier than 1 cycle after accept; there is at most one AR every 2 cycles.
- Round-robin:
  - If both contexts are eligible, take ctx == rr.
  - If only one is eligible, take it; rr is unchanged.
- R path:
  - Beat handshake = rvalid&rready. On a beat, ctx=rid[0]: to_recv[ctx]--.
  - If rresp!=0, set err[ctx].
  - If rlast is also set, outstanding--.
  - rd_last = (to_recv[rid[0]]==1).
- Done: when to_recv reaches 0 on a beat, done[ctx] pulses the next cycle and busy clears with it; req_ready rises that same cycle.
- Simultaneous AR handshake and rlast: outstanding unchanged.
- Both req_valid in the same cycle: both accepted independently.
- Protocol error: an R beat for a context with to_recv==0 is dropped from the accounting. No underflow, no done pulse.
- Reset mid-operation: all state clears immediately. In-flight R beats after reset are ignored (to_recv==0 rule). The system resets HBM alongside.

Test Plan:
- ctx0 job addr=0x0000, beats=40, arready=1, rready=1, HBM returns in order -> AR bursts arlen 15,15,7 at 0x000, 0x200, 0x400; 40 rd beats, rd_last on 40th; done[0] pulse once; err=0.
- ctx0 addr=0x0F80, beats=10 -> bursts arlen=3 @0x0F80 then arlen=5 @0x1000 (no 4 KB crossing); done after 10 beats.
- Both contexts beats=48 accepted same cycle -> arid alternates 0,1,0,1,0,1; both done pulses; rd_ctx matches rid.
- MAX_OUTSTANDING=2, HBM withholds R -> exactly 2 AR handshakes, then arvalid stays 0. Releasing one rlast allows the next AR, whose fields are stable while arready is held low for 5 cycles.
- Inject rresp=2'b10 on beat 3 of a ctx1 job -> err[1]=1 until the next ctx1 accept; done still pulses; req_beats=0 accept -> done the next cycle, no AR.
- Assert pcie_areset mid-job (to_issue>0) -> next cycle arvalid=0, req_ready=2'b11; stray R beats produce no done; a new job completes normally.

Source files
------------

// File: rtl/spmv_hbm_rd_scheduler.sv
// Read-side HBM AXI3 scheduler for the SpMV vector loader: splits two linear jobs
// (ctx0 Y readback, ctx1 X prefetch) into 4 KB-safe bursts and routes R beats back by context.
module spmv_hbm_rd_scheduler #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter logic [5:0]  ID_BASE         = 6'h0,
    parameter int unsigned BEAT_W          = 16
) (
    input  logic                   pcie_aclk,
    input  logic                   pcie_areset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][32:0]       req_addr,
    input  logic [1:0][BEAT_W-1:0] req_beats,
    output logic [1:0]             done,
    output logic [1:0]             err,
    output logic [32:0]            m_axi_hbm_araddr,
    output logic [1:0]             m_axi_hbm_arburst,
    output logic [5:0]             m_axi_hbm_arid,
    output logic [3:0]             m_axi_hbm_arlen,
    output logic [2:0]             m_axi_hbm_arsize,
    output logic                   m_axi_hbm_arvalid,
    input  logic                   m_axi_hbm_arready,
    input  logic [255:0]           m_axi_hbm_rdata,
    input  logic [5:0]             m_axi_hbm_rid,
    input  logic                   m_axi_hbm_rlast,
    input  logic [1:0]             m_axi_hbm_rresp,
    input  logic                   m_axi_hbm_rvalid,
    output logic                   m_axi_hbm_rready,
    output logic [255:0]           rd_data,
    output logic                   rd_valid,
    output logic                   rd_ctx,
    output logic                   rd_last,
    input  logic                   rd_ready
);

    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    state_t                 state_q, state_d;
    logic [1:0][32:0]       next_addr;
    logic [1:0][BEAT_W-1:0] to_issue;
    logic [1:0][BEAT_W-1:0] to_recv;
    logic [1:0]             busy;
    logic [3:0]             outstanding;
    logic                   rr;
    logic                   ar_ctx;
    logic [4:0]             ar_len;

    logic [1:0][4:0]        burst_len;
    logic [1:0]             eligible;
    logic                   load_ar;
    logic                   sel_ctx;
    logic                   ar_hs;
    logic                   r_hs;
    logic                   r_ctx;
    logic                   r_counted;
    logic                   unused_bits;

    // Burst = min(16, remaining, beats left before the next 4 KB boundary).
    function automatic logic [4:0] calc_len(input logic [6:0] beat_off,
                                            input logic [BEAT_W-1:0] left);
        logic [7:0] to_bnd;
        logic [7:0] len;
        to_bnd = 8'd128 - {1'b0, beat_off};
        len    = 8'd16;
        if (left < BEAT_W'(16)) len = 8'(left);
        if (to_bnd < len) len = to_bnd;
        return 5'(len);
    endfunction

    assign req_ready         = ~busy;
    assign m_axi_hbm_arburst = 2'b01;
    assign m_axi_hbm_arsize  = 3'b101;
    assign m_axi_hbm_arvalid = (state_q == ST_ISSUE);
    assign m_axi_hbm_rready  = rd_ready;
    assign rd_data           = m_axi_hbm_rdata;
    assign rd_valid          = m_axi_hbm_rvalid;
    assign rd_ctx            = m_axi_hbm_rid[0];

    assign ar_hs     = m_axi_hbm_arvalid & m_axi_hbm_arready;
    assign r_hs      = m_axi_hbm_rvalid & rd_ready;
    assign r_ctx     = m_axi_hbm_rid[0];
    // Beats for a context with nothing pending are stray and never touch the accounting.
    assign r_counted = r_hs && (to_recv[r_ctx] != '0);
    assign rd_last   = (to_recv[r_ctx] == BEAT_W'(1));

    assign unused_bits = ^{req_addr[0][4:0], req_addr[1][4:0], m_axi_hbm_rid[5:1]};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            burst_len[c] = calc_len(next_addr[c][11:5], to_issue[c]);
            eligible[c]  = busy[c] && (to_issue[c] != '0);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch can be inferred.
        state_d = state_q;
        load_ar = 1'b0;
        sel_ctx = rr;
        if (eligible == 2'b01) sel_ctx = 1'b0;
        else if (eligible == 2'b10) sel_ctx = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if ((eligible != 2'b00) && (32'(outstanding) < MAX_OUTSTANDING)) begin
                    load_ar = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: if (m_axi_hbm_arready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pcie_aclk) begin
        if (pcie_areset) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_ff @(posedge pcie_aclk) begin
        if (pcie_areset) begin
            m_axi_hbm_araddr <= '0;
            m_axi_hbm_arlen  <= '0;
            m_axi_hbm_arid   <= ID_BASE;
            ar_ctx           <= 1'b0;
            ar_len           <= '0;
            outstanding      <= '0;
            rr               <= 1'b0;
        end else begin
            if (load_ar) begin
                m_axi_hbm_araddr <= next_addr[sel_ctx];
                m_axi_hbm_arlen  <= 4'(burst_len[sel_ctx] - 5'd1);
                m_axi_hbm_arid   <= ID_BASE | {5'b0, sel_ctx};
                ar_ctx           <= sel_ctx;
                ar_len           <= burst_len[sel_ctx];
            end
            if (ar_hs) rr <= ~ar_ctx;
            if (ar_hs && !(r_counted && m_axi_hbm_rlast))
                outstanding <= outstanding + 4'd1;
            else if (!ar_hs && r_counted && m_axi_hbm_rlast)
                outstanding <= outstanding - 4'd1;
        end
    end

    always_ff @(posedge pcie_aclk) begin
        if (pcie_areset) begin
            next_addr <= '0;
            to_issue  <= '0;
            to_recv   <= '0;
            busy      <= '0;
            err       <= '0;
            done      <= '0;
        end else begin
            done <= '0;
            for (int c = 0; c < 2; c++) begin
                if (req_valid[c] && !busy[c]) begin
                    next_addr[c] <= {req_addr[c][32:5], 5'b0};
                    to_issue[c]  <= req_beats[c];
                    to_recv[c]   <= req_beats[c];
                    busy[c]      <= 1'b1;
                    err[c]       <= 1'b0;
                    done[c]      <= (req_beats[c] == '0);
                end else begin
                    if (ar_hs && (ar_ctx == c[0])) begin
                        next_addr[c] <= next_addr[c] + {23'd0, ar_len, 5'd0};
                        to_issue[c]  <= to_issue[c] - BEAT_W'(ar_len);
                    end
                    if (r_counted && (r_ctx == c[0])) begin
                        to_recv[c] <= to_recv[c] - BEAT_W'(1);
                        if (m_axi_hbm_rresp != 2'b00) err[c] <= 1'b1;
                        if (to_recv[c] == BEAT_W'(1)) begin
                            done[c] <= 1'b1;
                            busy[c] <= 1'b0;
                        end
                    end else if (busy[c] && (to_recv[c] == '0)) begin
                        // Zero-length job: its done pulse was raised on accept.
                        busy[c] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
